// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time
// and drives the IF/ID register, obeying hazard stalls and EX-stage branch flushes.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PC_Write,
   input  logic        IF_ID_Write,
   input  logic        Branch_Taken,
   input  logic [31:0] Branch_Target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_ID_PC,
   output logic [31:0] IF_ID_Instr,
   output logic        IF_ID_Valid
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        discard_q, discard_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic        ifid_vld_q, ifid_vld_d;

   logic        go;
   logic [31:0] tgt;

   assign go  = PC_Write & IF_ID_Write;
   assign tgt = Branch_Target & 32'hFFFF_FFFC;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      addr_d       = addr_q;
      discard_d    = discard_q;
      buf_d        = buf_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_vld_d   = ifid_vld_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_ready && !discard_q && go) begin
               ifid_pc_d    = pc_q;
               ifid_instr_d = imem_rdata;
               ifid_vld_d   = 1'b1;
               pc_d         = pc_q + 32'd4;
            end else if (imem_ready && !discard_q) begin
               buf_d   = imem_rdata;
               state_d = HOLD;
            end else begin
               // Dropped (discarded) responses are treated like an empty cycle.
               if (imem_ready) discard_d = 1'b0;
               if (IF_ID_Write) begin
                  ifid_pc_d    = pc_q;
                  ifid_instr_d = NOP_INSTR;
                  ifid_vld_d   = 1'b0;
               end
            end
         end
         HOLD: begin
            if (go) begin
               ifid_pc_d    = pc_q;
               ifid_instr_d = buf_q;
               ifid_vld_d   = 1'b1;
               pc_d         = pc_q + 32'd4;
               state_d      = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
      // Flush overrides everything; leaving HOLD is what invalidates the buffer.
      if (Branch_Taken) begin
         pc_d         = tgt;
         ifid_pc_d    = tgt;
         ifid_instr_d = NOP_INSTR;
         ifid_vld_d   = 1'b0;
         state_d      = REQ;
         if (state_q == REQ) begin
            if (imem_ready) begin
               discard_d = 1'b0;
            end else begin
               // Keep presenting the in-flight address until its response is dropped.
               if (!discard_q) addr_d = pc_q;
               discard_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         addr_q       <= RESET_PC;
         discard_q    <= 1'b0;
         buf_q        <= NOP_INSTR;
         ifid_pc_q    <= 32'h0;
         ifid_instr_q <= NOP_INSTR;
         ifid_vld_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         addr_q       <= addr_d;
         discard_q    <= discard_d;
         buf_q        <= buf_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_vld_q   <= ifid_vld_d;
      end
   end

   assign imem_req    = (state_q == REQ);
   assign imem_addr   = discard_q ? addr_q : pc_q;
   assign IF_ID_PC    = ifid_pc_q;
   assign IF_ID_Instr = ifid_instr_q;
   assign IF_ID_Valid = ifid_vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed per-cycle vectors for fetch_unit; the stimulus pushes hand-computed expected
// outputs into a scoreboard queue and a monitor compares them after each rising edge.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, PC_Write, IF_ID_Write, Branch_Taken, imem_ready;
   logic [31:0] Branch_Target, imem_rdata;
   logic        imem_req, IF_ID_Valid;
   logic [31:0] imem_addr, IF_ID_PC, IF_ID_Instr;

   fetch_unit dut (
      .clk(clk), .rst(rst), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
      .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .IF_ID_PC(IF_ID_PC), .IF_ID_Instr(IF_ID_Instr),
      .IF_ID_Valid(IF_ID_Valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        vld;
      int          id;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Distinct instruction word per fetch address.
   function automatic logic [31:0] ins(input logic [31:0] a);
      return 32'hA000_0000 ^ a;
   endfunction

   // Drive one cycle of inputs and record what the outputs must be after the next edge.
   task automatic v(input logic r, input logic bt, input logic [31:0] t,
                    input logic pw, input logic iw, input logic rdy, input logic [31:0] rd,
                    input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pc,
                    input logic [31:0] e_ins, input logic e_vld);
      exp_t e;
      @(negedge clk);
      rst = r; Branch_Taken = bt; Branch_Target = t;
      PC_Write = pw; IF_ID_Write = iw; imem_ready = rdy; imem_rdata = rd;
      e.req = e_req; e.addr = e_addr; e.pc = e_pc; e.ins = e_ins; e.vld = e_vld;
      e.id = n_vec;
      n_vec++;
      exp_q.push_back(e);
   endtask

   // Shorthand for a plain running cycle: no reset, no branch, no stall.
   task automatic run(input logic rdy, input logic [31:0] rd, input logic e_req,
                      input logic [31:0] e_addr, input logic [31:0] e_pc,
                      input logic [31:0] e_ins, input logic e_vld);
      v(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, rdy, rd, e_req, e_addr, e_pc, e_ins, e_vld);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (imem_req !== e.req) begin
            n_bad++; $display("FAIL v%0d imem_req: got %0b want %0b", e.id, imem_req, e.req);
         end
         if (imem_addr !== e.addr) begin
            n_bad++; $display("FAIL v%0d imem_addr: got %h want %h", e.id, imem_addr, e.addr);
         end
         if (IF_ID_PC !== e.pc) begin
            n_bad++; $display("FAIL v%0d IF_ID_PC: got %h want %h", e.id, IF_ID_PC, e.pc);
         end
         if (IF_ID_Instr !== e.ins) begin
            n_bad++; $display("FAIL v%0d IF_ID_Instr: got %h want %h", e.id, IF_ID_Instr, e.ins);
         end
         if (IF_ID_Valid !== e.vld) begin
            n_bad++; $display("FAIL v%0d IF_ID_Valid: got %0b want %0b", e.id, IF_ID_Valid, e.vld);
         end
      end
   end

   initial begin
      rst = 1'b1; Branch_Taken = 1'b0; Branch_Target = 32'h0;
      PC_Write = 1'b1; IF_ID_Write = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0;

      // Reset values, then first request in the cycle after reset falls
      v(1, 0, 0, 1, 1, 0, 0,           0, 32'h0,  32'h0, NOP, 0);
      run(0, 0,                        1, 32'h0,  32'h0, NOP, 0);
      // Zero-wait streaming
      run(1, ins(32'h0),               1, 32'h4,  32'h0,  ins(32'h0),  1);
      run(1, ins(32'h4),               1, 32'h8,  32'h4,  ins(32'h4),  1);
      run(1, ins(32'h8),               1, 32'hC,  32'h8,  ins(32'h8),  1);
      run(1, ins(32'hC),               1, 32'h10, 32'hC,  ins(32'hC),  1);
      // Two wait states: bubbles in between, address stable
      run(0, 0,                        1, 32'h10, 32'h10, NOP, 0);
      run(0, 0,                        1, 32'h10, 32'h10, NOP, 0);
      run(1, ins(32'h10),              1, 32'h14, 32'h10, ins(32'h10), 1);
      run(0, 0,                        1, 32'h14, 32'h14, NOP, 0);
      run(0, 0,                        1, 32'h14, 32'h14, NOP, 0);
      run(1, ins(32'h14),              1, 32'h18, 32'h14, ins(32'h14), 1);
      // Two-cycle full stall arriving with ready -> HOLD, then release
      v(0, 0, 0, 0, 0, 1, ins(32'h18), 0, 32'h18, 32'h14, ins(32'h14), 1);
      v(0, 0, 0, 0, 0, 0, 0,           0, 32'h18, 32'h14, ins(32'h14), 1);
      run(0, 0,                        1, 32'h1C, 32'h18, ins(32'h18), 1);
      // Partial stall (PC_Write only) also buffers
      v(0, 0, 0, 1, 0, 1, ins(32'h1C), 0, 32'h1C, 32'h18, ins(32'h18), 1);
      run(0, 0,                        1, 32'h20, 32'h1C, ins(32'h1C), 1);
      // No ready with IF_ID_Write low holds IF/ID
      v(0, 0, 0, 1, 0, 0, 0,           1, 32'h20, 32'h1C, ins(32'h1C), 1);
      // Branch to 0x100 with request at 0x20 in flight (ready two cycles later)
      v(0, 1, 32'h100, 1, 1, 0, 0,     1, 32'h20, 32'h100, NOP, 0);
      run(0, 0,                        1, 32'h20, 32'h100, NOP, 0);
      run(1, ins(32'h20),              1, 32'h100, 32'h100, NOP, 0);
      run(1, ins(32'h100),             1, 32'h104, 32'h100, ins(32'h100), 1);
      // Branch coincident with stall and ready: flush wins, nothing buffered
      v(0, 1, 32'h200, 0, 0, 1, ins(32'h104), 1, 32'h200, 32'h200, NOP, 0);
      run(1, ins(32'h200),             1, 32'h204, 32'h200, ins(32'h200), 1);
      // Branch out of HOLD
      v(0, 0, 0, 0, 0, 1, ins(32'h204), 0, 32'h204, 32'h200, ins(32'h200), 1);
      v(0, 1, 32'h300, 0, 0, 0, 0,     1, 32'h300, 32'h300, NOP, 0);
      run(1, ins(32'h300),             1, 32'h304, 32'h300, ins(32'h300), 1);
      // Wrap at top of address space, and misaligned target
      v(0, 1, 32'hFFFF_FFFC, 1, 1, 1, ins(32'h304), 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP, 0);
      run(1, ins(32'hFFFF_FFFC),       1, 32'h0, 32'hFFFF_FFFC, ins(32'hFFFF_FFFC), 1);
      v(0, 1, 32'h103, 1, 1, 1, ins(32'h0), 1, 32'h100, 32'h100, NOP, 0);
      run(1, ins(32'h100),             1, 32'h104, 32'h100, ins(32'h100), 1);
      // Reset mid-request abandons it
      v(1, 0, 0, 1, 1, 0, 0,           0, 32'h0, 32'h0, NOP, 0);
      run(0, 0,                        1, 32'h0, 32'h0, NOP, 0);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
